// File: rtl/bus_gate_arb_pkg.sv
// Shared types and sizing helpers for the bus gate arbiter.
// Imported by the round-robin selector and the top level.
package bus_gate_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Ceiling log2 that never returns less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bus_gate_arb_rr_pick.sv
// Combinational round-robin selector: first requester strictly after last_owner,
// wrapping from CHANNELS-1 back to 0.
module rr_pick
   import bus_gate_arb_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int OW       = clog2_min1(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [OW-1:0]       last_owner,
   output logic [CHANNELS-1:0] pick,
   output logic [OW-1:0]       index
);

   always_comb begin
      logic          found;
      int            c;
      logic [OW-1:0] c_idx;
      // NOTE: every output gets a default before the search loop, so no path
      // through this block can leave a value unassigned and infer a latch.
      pick  = '0;
      index = '0;
      found = 1'b0;
      c     = 0;
      c_idx = '0;
      for (int off = 1; off <= CHANNELS; off++) begin
         c     = (int'(last_owner) + off) % CHANNELS;
         c_idx = OW'(c);
         if (!found && req[c_idx]) begin
            found       = 1'b1;
            pick[c_idx] = 1'b1;
            index       = c_idx;
         end
      end
   end

endmodule

// File: rtl/bus_gate_arb.sv
// Multi-channel bus gate: round-robin grant, AND-gated registered bus output
// and a burst limit that forces the owner to release the bus.
module bus_gate_arb
   import bus_gate_arb_pkg::*;
#(
   parameter int  WIDTH     = 8,
   parameter int  CHANNELS  = 4,
   parameter int  MAX_BURST = 8,
   localparam int OW        = clog2_min1(CHANNELS),
   localparam int CW        = clog2_min1(MAX_BURST + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       req,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic                      gate_en,
   output logic [CHANNELS-1:0]       grant,
   output logic [OW-1:0]             owner,
   output logic [WIDTH-1:0]          bus_out,
   output logic                      bus_valid
);

   state_t              state, state_nxt;
   logic [CHANNELS-1:0] grant_nxt, pick;
   logic [OW-1:0]       owner_nxt, pick_idx, last_owner, last_owner_nxt;
   logic [CW-1:0]       count, count_nxt;
   logic [WIDTH-1:0]    gated_word, bus_nxt;
   logic                valid_nxt;

   rr_pick #(
      .CHANNELS (CHANNELS),
      .OW       (OW)
   ) u_rr_pick (
      .req        (req),
      .last_owner (last_owner),
      .pick       (pick),
      .index      (pick_idx)
   );

   // Each word is masked by its own grant bit, so a non-owner can never leak.
   always_comb begin
      gated_word = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         gated_word |= data_in[i*WIDTH +: WIDTH] & {WIDTH{grant[i] & gate_en}};
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      count_nxt      = count;
      bus_nxt        = '0;
      valid_nxt      = 1'b0;
      case (state)
         ST_IDLE: begin
            grant_nxt = '0;
            if (|req) begin
               grant_nxt      = pick;
               owner_nxt      = pick_idx;
               last_owner_nxt = pick_idx;
               count_nxt      = '0;
               state_nxt      = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!req[owner]) begin
               grant_nxt = '0;
               state_nxt = ST_IDLE;
            end else if (gate_en) begin
               bus_nxt   = gated_word;
               valid_nxt = 1'b1;
               count_nxt = count + CW'(1);
               // The last permitted word still transfers on this edge.
               if (count == CW'(MAX_BURST - 1)) begin
                  grant_nxt = '0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= '0;
         owner      <= '0;
         last_owner <= OW'(CHANNELS - 1);
         count      <= '0;
         bus_out    <= '0;
         bus_valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         count      <= count_nxt;
         bus_out    <= bus_nxt;
         bus_valid  <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_bus_gate_arb.sv
// Directed bench for bus_gate_arb: reset, round-robin cycling, burst limit,
// gate freeze, owner release and asynchronous reset mid-burst.
module tb_bus_gate_arb;

   localparam int WIDTH     = 8;
   localparam int CHANNELS  = 4;
   localparam int MAX_BURST = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic        gate_en;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic [7:0]  bus_out;
   logic        bus_valid;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  ch_word [4];

   always #5 clk = ~clk;

   bus_gate_arb #(
      .WIDTH     (WIDTH),
      .CHANNELS  (CHANNELS),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .gate_en   (gate_en),
      .grant     (grant),
      .owner     (owner),
      .bus_out   (bus_out),
      .bus_valid (bus_valid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      req     = 4'b0000;
      gate_en = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      ch_word[0] = 8'hA5;
      ch_word[1] = 8'hFF;
      ch_word[2] = 8'h5C;
      ch_word[3] = 8'h3C;
      data_in    = {ch_word[3], ch_word[2], ch_word[1], ch_word[0]};
      rst        = 1'b1;
      req        = 4'b0000;
      gate_en    = 1'b1;
      step();
      step();
      check("reset_grant", 32'(grant), 32'h0);
      check("reset_owner", 32'(owner), 32'h0);
      check("reset_bus_out", 32'(bus_out), 32'h0);
      check("reset_valid", 32'(bus_valid), 32'h0);
      rst = 1'b0;

      // Single requester: grant one edge later, word on the next edge.
      req = 4'b0001;
      step();
      check("first_grant", 32'(grant), 32'h1);
      check("first_grant_valid", 32'(bus_valid), 32'h0);
      step();
      check("first_word", 32'(bus_out), 32'hA5);
      check("first_word_valid", 32'(bus_valid), 32'h1);

      // All channels requesting: 0,1,2,3,0 with 8 words each and a dead cycle.
      do_reset();
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step();
         check($sformatf("rr_grant_%0d", g), 32'(grant), 32'(4'b0001 << (g % 4)));
         check($sformatf("rr_owner_%0d", g), 32'(owner), 32'(g % 4));
         check($sformatf("rr_dead_valid_%0d", g), 32'(bus_valid), 32'h0);
         for (int w = 0; w < MAX_BURST; w++) begin
            step();
            check($sformatf("rr_valid_%0d_%0d", g, w), 32'(bus_valid), 32'h1);
            check($sformatf("rr_word_%0d_%0d", g, w), 32'(bus_out), 32'(ch_word[g % 4]));
            check($sformatf("rr_hold_%0d_%0d", g, w), 32'(grant),
                  (w == MAX_BURST - 1) ? 32'h0 : 32'(4'b0001 << (g % 4)));
         end
      end
      req = 4'b0000;
      step();
      check("rr_end_valid", 32'(bus_valid), 32'h0);
      check("rr_end_grant", 32'(grant), 32'h0);

      // Gate low for three cycles mid-burst on ch2: count frozen, 8 words total.
      do_reset();
      req = 4'b0100;
      step();
      check("gate_grant", 32'(grant), 32'h4);
      check("gate_owner", 32'(owner), 32'h2);
      for (int w = 0; w < 2; w++) begin
         step();
         check($sformatf("gate_pre_word_%0d", w), 32'(bus_out), 32'h5C);
         check($sformatf("gate_pre_valid_%0d", w), 32'(bus_valid), 32'h1);
      end
      gate_en = 1'b0;
      for (int w = 0; w < 3; w++) begin
         step();
         check($sformatf("gate_off_bus_%0d", w), 32'(bus_out), 32'h0);
         check($sformatf("gate_off_valid_%0d", w), 32'(bus_valid), 32'h0);
         check($sformatf("gate_off_grant_%0d", w), 32'(grant), 32'h4);
      end
      gate_en = 1'b1;
      for (int w = 0; w < 6; w++) begin
         step();
         check($sformatf("gate_post_valid_%0d", w), 32'(bus_valid), 32'h1);
         check($sformatf("gate_post_word_%0d", w), 32'(bus_out), 32'h5C);
         check($sformatf("gate_post_grant_%0d", w), 32'(grant), (w == 5) ? 32'h0 : 32'h4);
      end
      step();
      check("gate_dead_valid", 32'(bus_valid), 32'h0);

      // ch1 drops after 3 words while ch3 waits.
      do_reset();
      req = 4'b1010;
      step();
      check("drop_grant", 32'(grant), 32'h2);
      for (int w = 0; w < 3; w++) begin
         step();
         check($sformatf("drop_word_%0d", w), 32'(bus_out), 32'hFF);
      end
      req = 4'b1000;
      step();
      check("drop_release_grant", 32'(grant), 32'h0);
      check("drop_release_valid", 32'(bus_valid), 32'h0);
      check("drop_release_bus", 32'(bus_out), 32'h0);
      step();
      check("drop_next_grant", 32'(grant), 32'h8);
      check("drop_next_bus", 32'(bus_out), 32'h0);
      step();
      check("drop_next_word", 32'(bus_out), 32'h3C);
      check("drop_next_valid", 32'(bus_valid), 32'h1);

      // Asynchronous reset between edges while ch3 is mid-burst.
      #2;
      rst = 1'b1;
      #1;
      check("async_grant", 32'(grant), 32'h0);
      check("async_bus", 32'(bus_out), 32'h0);
      check("async_valid", 32'(bus_valid), 32'h0);
      #1;
      rst = 1'b0;
      req = 4'b1001;
      step();
      check("async_tie_grant", 32'(grant), 32'h1);
      check("async_tie_owner", 32'(owner), 32'h0);
      step();
      check("async_tie_word", 32'(bus_out), 32'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
